// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, state codes and fault rule for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int ST_W = 5;
    localparam logic [ST_W-1:0] ST_IDLE = 5'b00001;
    localparam logic [ST_W-1:0] ST_LD   = 5'b00010;
    localparam logic [ST_W-1:0] ST_RDW  = 5'b00100;
    localparam logic [ST_W-1:0] ST_ST   = 5'b01000;
    localparam logic [ST_W-1:0] ST_RSP  = 5'b10000;

    typedef enum logic [ST_W-1:0] {
        S_IDLE = ST_IDLE,
        S_LD   = ST_LD,
        S_RDW  = ST_RDW,
        S_ST   = ST_ST,
        S_RSP  = ST_RSP
    } state_t;

    // Natural alignment only; doublewords do not exist on a 32-bit datapath.
    function automatic logic lsu_fault(input logic [1:0] size, input logic [2:0] addr_lo,
                                       input int xlen);
        case (size)
            SZ_B:    lsu_fault = 1'b0;
            SZ_H:    lsu_fault = addr_lo[0];
            SZ_W:    lsu_fault = |addr_lo[1:0];
            default: lsu_fault = (xlen == 32) || (|addr_lo);
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - core request/response and data-memory channel bundle
interface lsu_if #(parameter int XLEN = 32) ();
    localparam int STRB_W = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [4:0]        req_rd;

    logic [XLEN-1:0]   Address;
    logic              MemWrite;
    logic              MemRead;
    logic [XLEN-1:0]   Write_data;
    logic [STRB_W-1:0] Write_strb;
    logic              Mem_Req_Ready;
    logic [XLEN-1:0]   Read_data;
    logic              Read_data_Valid;
    logic              Read_data_Ready;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic [4:0]        rsp_rd;
    logic              rsp_fault;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        input  Mem_Req_Ready, Read_data, Read_data_Valid, rsp_ready,
        output req_ready, Address, MemWrite, MemRead, Write_data, Write_strb,
        output Read_data_Ready, rsp_valid, rsp_data, rsp_rd, rsp_fault
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        output Mem_Req_Ready, Read_data, Read_data_Valid, rsp_ready,
        input  req_ready, Address, MemWrite, MemRead, Write_data, Write_strb,
        input  Read_data_Ready, rsp_valid, rsp_data, rsp_rd, rsp_fault
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane placement and load extraction/extension
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]                   i_size,
    input  logic                         i_unsigned,
    input  logic [$clog2(XLEN/8)-1:0]    i_lane,
    input  logic [XLEN-1:0]              i_wdata,
    input  logic [XLEN-1:0]              i_rdata,
    output logic [XLEN-1:0]              o_wdata,
    output logic [(XLEN/8)-1:0]          o_strb,
    output logic [XLEN-1:0]              o_ldata
);
    logic [3:0]      w_nbytes;
    logic [15:0]     w_strb_wide;
    logic [XLEN-1:0] w_shifted;
    logic            w_sign;

    assign w_nbytes    = 4'd1 << i_size;
    assign w_strb_wide = ((16'd1 << w_nbytes) - 16'd1) << i_lane;
    assign o_strb      = w_strb_wide[(XLEN/8)-1:0];
    assign o_wdata     = i_wdata << {i_lane, 3'b000};
    assign w_shifted   = i_rdata >> {i_lane, 3'b000};

    always_comb begin
        w_sign  = 1'b0;
        o_ldata = '0;
        case (i_size)
            SZ_B:    w_sign = w_shifted[7];
            SZ_H:    w_sign = w_shifted[15];
            SZ_W:    w_sign = w_shifted[31];
            default: w_sign = w_shifted[XLEN-1];
        endcase
        if (i_unsigned) w_sign = 1'b0;
        for (int i = 0; i < XLEN; i++)
            o_ldata[i] = ((i / 8) < int'(w_nbytes)) ? w_shifted[i] : w_sign;
    end
endmodule

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - single-outstanding load/store unit: FSM, capture registers, cycle counters
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_if.slave        bus,
    output logic [31:0] ld_cycles,
    output logic [31:0] st_cycles
);
    localparam int LANE_W = $clog2(STRB_W);

    state_t            r_state, w_next;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [4:0]        r_rsp_rd;
    logic              r_fault;
    logic [XLEN-1:0]   r_rsp_data;
    logic [31:0]       r_ld_cycles, r_st_cycles;

    logic              w_fault, w_req_ready, w_mem_read, w_mem_write, w_rd_ready, w_rsp_valid;
    logic [XLEN-1:0]   w_wdata_lane, w_ldata;
    logic [STRB_W-1:0] w_strb;

    assign w_fault = lsu_fault(bus.req_size, bus.req_addr[2:0], XLEN);

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_lane     (r_addr[LANE_W-1:0]),
        .i_wdata    (r_wdata),
        .i_rdata    (bus.Read_data),
        .o_wdata    (w_wdata_lane),
        .o_strb     (w_strb),
        .o_ldata    (w_ldata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Strobes decode from state alone so no input reaches them combinationally.
    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_rd_ready  = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_fault)            w_next = S_RSP;
                    else if (bus.req_store) w_next = S_ST;
                    else                    w_next = S_LD;
                end
            end
            S_ST: begin
                w_mem_write = 1'b1;
                if (bus.Mem_Req_Ready) w_next = S_RSP;
            end
            S_LD: begin
                w_mem_read = 1'b1;
                if (bus.Mem_Req_Ready) w_next = S_RDW;
            end
            S_RDW: begin
                w_rd_ready = 1'b1;
                if (bus.Read_data_Valid) w_next = S_RSP;
            end
            S_RSP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size      <= '0;
            r_unsigned  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_rd    <= '0;
            r_fault     <= 1'b0;
            r_rsp_data  <= '0;
            r_ld_cycles <= '0;
            r_st_cycles <= '0;
        end else begin
            if (r_state == S_IDLE && bus.req_valid) begin
                r_size     <= bus.req_size;
                r_unsigned <= bus.req_unsigned;
                r_addr     <= bus.req_addr;
                r_wdata    <= bus.req_wdata;
                r_rsp_rd   <= bus.req_store ? 5'd0 : bus.req_rd;
                r_fault    <= w_fault;
                r_rsp_data <= '0;
            end
            if (r_state == S_RDW && bus.Read_data_Valid) r_rsp_data <= w_ldata;
            if (r_state == S_LD || r_state == S_RDW) r_ld_cycles <= r_ld_cycles + 32'd1;
            if (r_state == S_ST) r_st_cycles <= r_st_cycles + 32'd1;
        end
    end

    assign bus.req_ready       = w_req_ready;
    assign bus.MemRead         = w_mem_read;
    assign bus.MemWrite        = w_mem_write;
    assign bus.Read_data_Ready = w_rd_ready;
    assign bus.rsp_valid       = w_rsp_valid;
    assign bus.Address    = (w_mem_read || w_mem_write) ?
                            {r_addr[XLEN-1:LANE_W], {LANE_W{1'b0}}} : '0;
    assign bus.Write_data = w_mem_write ? w_wdata_lane : '0;
    assign bus.Write_strb = w_mem_write ? w_strb : '0;
    assign bus.rsp_data   = w_rsp_valid ? r_rsp_data : '0;
    assign bus.rsp_rd     = w_rsp_valid ? r_rsp_rd : '0;
    assign bus.rsp_fault  = w_rsp_valid ? r_fault : 1'b0;
    assign ld_cycles      = r_ld_cycles;
    assign st_cycles      = r_st_cycles;
endmodule

// File: tb/tb_lsu_unit.sv
// tb/tb_lsu_unit.sv - directed scoreboard bench for lsu_unit at XLEN 32 and 64
module tb_lsu_unit;
    import lsu_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        fault;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if #(.XLEN(32)) b32 ();
    lsu_if #(.XLEN(64)) b64 ();
    logic [31:0] ld32, st32, ld64, st64;

    lsu_unit #(.XLEN(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32), .ld_cycles(ld32), .st_cycles(st32));
    lsu_unit #(.XLEN(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64), .ld_cycles(ld64), .st_cycles(st64));

    int   errors = 0;
    int   checks = 0;
    rsp_t sb_q[$];
    logic [31:0] cnt_before;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic xact32(input string tag, input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdat, input int mstall, input int rstall,
                          input logic [31:0] e_addr, input logic [31:0] e_wd, input logic [3:0] e_strb,
                          input logic [31:0] e_data, input logic [4:0] e_rd, input logic e_fault,
                          input int e_lat);
        rsp_t exp;
        int   cyc, ms, rs;
        bit   done, seen_rsp, saw_rd, saw_wr;
        ms = mstall; rs = rstall;
        chk({tag, ".req_ready_idle"}, b32.req_ready, 1);
        b32.req_valid = 1'b1; b32.req_store = st; b32.req_size = sz; b32.req_unsigned = uns;
        b32.req_addr = a; b32.req_wdata = wd; b32.req_rd = rd;
        sb_q.push_back('{data: {32'd0, e_data}, rd: e_rd, fault: e_fault});
        @(posedge clk); @(negedge clk);
        b32.req_valid = 1'b0;
        cyc = 1; done = 0; seen_rsp = 0; saw_rd = 0; saw_wr = 0;
        while (!done && cyc < 40) begin
            chk({tag, ".req_ready_busy"}, b32.req_ready, 0);
            b32.Mem_Req_Ready = 1'b0; b32.Read_data_Valid = 1'b0; b32.rsp_ready = 1'b0;
            if (b32.MemRead || b32.MemWrite) begin
                saw_rd |= b32.MemRead;
                saw_wr |= b32.MemWrite;
                chk({tag, ".Address"}, b32.Address, e_addr);
                if (b32.MemWrite) begin
                    chk({tag, ".Write_data"}, b32.Write_data, e_wd);
                    chk({tag, ".Write_strb"}, b32.Write_strb, e_strb);
                end else begin
                    b32.Read_data_Valid = 1'b1;
                    b32.Read_data = ~rdat;
                end
                if (ms > 0) ms--;
                else b32.Mem_Req_Ready = 1'b1;
            end
            if (b32.Read_data_Ready) begin
                b32.Read_data = rdat;
                b32.Read_data_Valid = 1'b1;
            end
            if (b32.rsp_valid) begin
                if (!seen_rsp) chk({tag, ".latency"}, cyc, e_lat);
                seen_rsp = 1;
                chk({tag, ".sb_depth"}, sb_q.size(), 1);
                exp = (sb_q.size() > 0) ? sb_q[0] : '0;
                chk({tag, ".rsp_data"}, b32.rsp_data, exp.data);
                chk({tag, ".rsp_rd"}, b32.rsp_rd, exp.rd);
                chk({tag, ".rsp_fault"}, b32.rsp_fault, exp.fault);
                if (rs > 0) rs--;
                else begin
                    b32.rsp_ready = 1'b1;
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                    done = 1;
                end
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        b32.rsp_ready = 1'b0; b32.Mem_Req_Ready = 1'b0; b32.Read_data_Valid = 1'b0;
        chk({tag, ".completed"}, done, 1);
        chk({tag, ".saw_MemRead"}, saw_rd, !st && !e_fault);
        chk({tag, ".saw_MemWrite"}, saw_wr, st && !e_fault);
        chk({tag, ".req_ready_after"}, b32.req_ready, 1);
        chk({tag, ".rsp_valid_after"}, b32.rsp_valid, 0);
    endtask

    task automatic load64(input string tag, input logic [1:0] sz, input logic [63:0] a,
                          input logic [63:0] rdat, input logic [63:0] e_addr, input logic [63:0] e_data);
        rsp_t exp;
        int   cyc;
        bit   done;
        b64.req_valid = 1'b1; b64.req_store = 1'b0; b64.req_size = sz; b64.req_unsigned = 1'b0;
        b64.req_addr = a; b64.req_wdata = '0; b64.req_rd = 5'd12;
        sb_q.push_back('{data: e_data, rd: 5'd12, fault: 1'b0});
        @(posedge clk); @(negedge clk);
        b64.req_valid = 1'b0;
        cyc = 1; done = 0;
        while (!done && cyc < 40) begin
            b64.Mem_Req_Ready = b64.MemRead;
            if (b64.MemRead) chk({tag, ".Address"}, b64.Address, e_addr);
            b64.Read_data_Valid = b64.Read_data_Ready;
            b64.Read_data = rdat;
            b64.rsp_ready = b64.rsp_valid;
            if (b64.rsp_valid) begin
                chk({tag, ".latency"}, cyc, 3);
                chk({tag, ".sb_depth"}, sb_q.size(), 1);
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
                chk({tag, ".rsp_data"}, b64.rsp_data, exp.data);
                chk({tag, ".rsp_rd"}, b64.rsp_rd, exp.rd);
                done = 1;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        b64.rsp_ready = 1'b0; b64.Mem_Req_Ready = 1'b0; b64.Read_data_Valid = 1'b0;
        chk({tag, ".completed"}, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        b32.req_valid = 0; b32.req_store = 0; b32.req_size = 0; b32.req_unsigned = 0;
        b32.req_addr = 0; b32.req_wdata = 0; b32.req_rd = 0; b32.Mem_Req_Ready = 0;
        b32.Read_data = 0; b32.Read_data_Valid = 0; b32.rsp_ready = 0;
        b64.req_valid = 0; b64.req_store = 0; b64.req_size = 0; b64.req_unsigned = 0;
        b64.req_addr = 0; b64.req_wdata = 0; b64.req_rd = 0; b64.Mem_Req_Ready = 0;
        b64.Read_data = 0; b64.Read_data_Valid = 0; b64.rsp_ready = 0;
        repeat (2) @(negedge clk);

        chk("rst.req_ready", b32.req_ready, 1);
        chk("rst.MemRead", b32.MemRead, 0);
        chk("rst.MemWrite", b32.MemWrite, 0);
        chk("rst.rsp_valid", b32.rsp_valid, 0);
        chk("rst.Write_strb", b32.Write_strb, 0);
        chk("rst.ld_cycles", ld32, 0);
        chk("rst.st_cycles", st32, 0);
        rst_n = 1'b1;
        @(negedge clk);

        xact32("sb", 1, SZ_B, 0, 32'h1003, 32'h0000_00A5, 5'd4, 32'h0, 0, 0,
               32'h1000, 32'hA500_0000, 4'b1000, 32'h0, 5'd0, 0, 2);
        xact32("lb", 0, SZ_B, 0, 32'h1003, 32'h0, 5'd7, 32'h80FF_1234, 0, 0,
               32'h1000, 32'h0, 4'b0, 32'hFFFF_FF80, 5'd7, 0, 3);
        xact32("lbu", 0, SZ_B, 1, 32'h1003, 32'h0, 5'd7, 32'h80FF_1234, 0, 0,
               32'h1000, 32'h0, 4'b0, 32'h0000_0080, 5'd7, 0, 3);
        xact32("sh", 1, SZ_H, 0, 32'h2002, 32'h0000_BEEF, 5'd0, 32'h0, 0, 0,
               32'h2000, 32'hBEEF_0000, 4'b1100, 32'h0, 5'd0, 0, 2);
        xact32("lh", 0, SZ_H, 0, 32'h1002, 32'h0, 5'd3, 32'h80FF_1234, 0, 0,
               32'h1000, 32'h0, 4'b0, 32'hFFFF_80FF, 5'd3, 0, 3);
        xact32("lw_mis", 0, SZ_W, 0, 32'h1001, 32'h0, 5'd3, 32'hDEAD_BEEF, 0, 0,
               32'h0, 32'h0, 4'b0, 32'h0, 5'd3, 1, 1);
        xact32("ld_on32", 0, SZ_D, 0, 32'h1000, 32'h0, 5'd8, 32'hDEAD_BEEF, 0, 0,
               32'h0, 32'h0, 4'b0, 32'h0, 5'd8, 1, 1);

        cnt_before = ld32;
        xact32("lw_bp", 0, SZ_W, 0, 32'h1004, 32'h0, 5'd9, 32'h1234_5678, 3, 2,
               32'h1004, 32'h0, 4'b0, 32'h1234_5678, 5'd9, 0, 6);
        chk("ld_cycles_delta", ld32 - cnt_before, 5);

        cnt_before = st32;
        xact32("sw_bp", 1, SZ_W, 0, 32'h3000, 32'hCAFE_F00D, 5'd2, 32'h0, 2, 1,
               32'h3000, 32'hCAFE_F00D, 4'b1111, 32'h0, 5'd0, 0, 4);
        chk("st_cycles_delta", st32 - cnt_before, 3);

        load64("ld64", SZ_D, 64'h0000_0000_0000_0108, 64'h1122_3344_5566_7788,
               64'h0000_0000_0000_0108, 64'h1122_3344_5566_7788);
        load64("lw64", SZ_W, 64'h0000_0000_0000_0104, 64'h8000_0001_DEAD_BEEF,
               64'h0000_0000_0000_0100, 64'hFFFF_FFFF_8000_0001);

        b32.req_valid = 1'b1; b32.req_store = 1'b0; b32.req_size = SZ_W; b32.req_unsigned = 1'b0;
        b32.req_addr = 32'h4000; b32.req_rd = 5'd5;
        @(posedge clk); @(negedge clk);
        b32.req_valid = 1'b0; b32.Mem_Req_Ready = 1'b1;
        @(posedge clk); @(negedge clk);
        b32.Mem_Req_Ready = 1'b0;
        chk("rstmid.in_rdw", b32.Read_data_Ready, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.req_ready", b32.req_ready, 1);
        chk("rstmid.rsp_valid", b32.rsp_valid, 0);
        chk("rstmid.Read_data_Ready", b32.Read_data_Ready, 0);
        chk("rstmid.ld_cycles", ld32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        b32.Read_data_Valid = 1'b1; b32.Read_data = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            chk("late_rdv.rsp_valid", b32.rsp_valid, 0);
            chk("late_rdv.req_ready", b32.req_ready, 1);
        end
        b32.Read_data_Valid = 1'b0;
        chk("sb_empty_end", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_unit.md
# lsu_unit

Parametrised load/store unit. It carries a single memory instruction from the CPU core's execute stage to the data-memory request/response channels and returns aligned, extended load data tagged with the destination register. Compared with the in-core memory states of the multi-cycle RV32 CPU, it adds:
- width generalisation (XLEN 32/64, including LD/SD/LWU);
- misaligned-access detection with no bus traffic;
- output backpressure;
- its own cycle counters.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- STRB_W, XLEN/8, byte-strobe width (derived; do not override).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core offers a command.
- req_ready  out  1  unit can accept a command.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  zero-extend the load result.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- req_rd  in  5  load destination register.
- Address  out  XLEN  aligned bus address; low log2(STRB_W) bits are 0.
- MemWrite  out  1  write request.
- MemRead  out  1  read request.
- Write_data  out  XLEN  lane-shifted store data.
- Write_strb  out  STRB_W  byte enables.
- Mem_Req_Ready  in  1  memory accepts the request.
- Read_data  in  XLEN  raw read word.
- Read_data_Valid  in  1  read data present.
- Read_data_Ready  out  1  unit accepts read data.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  core takes the result.
- rsp_data  out  XLEN  extended load data; 0 for stores and faults.
- rsp_rd  out  5  echoed req_rd; 0 for stores.
- rsp_fault  out  1  misaligned access, or size 3 when XLEN = 32.
- ld_cycles  out  32  cycles spent in LD + RDW.
- st_cycles  out  32  cycles spent in ST.

## Operation
- States: IDLE, LD, RDW, ST, RSP. One-hot encoding.
- Reset values: state IDLE; all outputs 0 except req_ready = 1; counters 0.
- IDLE
  - req_ready = 1.
  - On req_valid, capture the command. Then go to:
    - RSP, with fault = 1, if the command faults;
    - ST if it is a store;
    - LD if it is a load.
- Fault rule: addr mod 2^size ≠ 0, or size 3 while XLEN = 32. A faulting command causes no MemRead or MemWrite.
- ST
  - MemWrite = 1. Address, Write_data and Write_strb are held stable until Mem_Req_Ready.
  - On Mem_Req_Ready, go to RSP.
- LD
  - MemRead = 1, held until Mem_Req_Ready.
  - On Mem_Req_Ready, go to RDW.
- RDW
  - Read_data_Ready = 1.
  - On Read_data_Valid, capture the extracted and extended data, then go to RSP.
- RSP
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On rsp_ready, go to IDLE.
- Store lane placement:
  - lane = addr mod STRB_W.
  - Write_data = req_wdata << (8·lane).
  - Write_strb = ((1 << 2^size) − 1) << lane.
- Load extraction: take 2^size bytes of Read_data starting at byte lane. Sign-extend, or zero-extend if req_unsigned, to XLEN.
- Counters:
  - ld_cycles += 1 for each cycle in LD or RDW; st_cycles += 1 for each cycle in ST.
  - Both wrap modulo 2^32.
- Unknown or one-hot-invalid state returns to IDLE.

## Timing
- Acceptance cycle is t0. Minimum latency to rsp_valid:
  - store: t2 (ST at t1 with Mem_Req_Ready = 1);
  - load: t3;
  - fault: t1.
- Each wait-for-ready adds one cycle per stall cycle. No combinational path from any input to req_ready, MemRead or MemWrite.
- Single outstanding command: req_ready = 0 from t1 until the cycle after the RSP handshake.
- Simultaneous Mem_Req_Ready and Read_data_Valid in LD: Read_data_Valid is ignored. Data is accepted only in RDW.
- rst_n low at any point (including mid-RDW):
  - state is forced to IDLE asynchronously and all request and response strobes drop immediately;
  - a late Read_data_Valid after release is ignored, because Read_data_Ready = 0 in IDLE.

## Structure
- Package lsu_pkg holds:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D);
  - state one-hot localparams;
  - a function computing the fault flag from size, address low bits and XLEN.
- Sub-module lsu_align (combinational, parameter XLEN) produces Write_data, Write_strb and the extracted/extended load data. lsu_unit contains the FSM, capture registers and counters.

## Test plan
- XLEN = 32, sb at 0x1003, data 0x0000_00A5, Mem_Req_Ready = 1.
  - Expect Address 0x1000, Write_data 0xA500_0000, Write_strb 1000b.
  - Expect rsp_valid at t2 with rsp_fault = 0.
- XLEN = 32, lb at 0x1003, rd 7, Read_data 0x80FF_1234.
  - Expect rsp_data 0xFFFF_FF80, rsp_rd 7.
  - The same command with lbu gives 0x0000_0080.
- XLEN = 32, sh at 0x2002, data 0x0000_BEEF.
  - Expect Address 0x2000, Write_data 0xBEEF_0000, Write_strb 1100b.
- XLEN = 32, lw at 0x1001.
  - Expect rsp_fault = 1 at t1, rsp_data 0.
  - MemRead never asserted.
- Backpressure: Mem_Req_Ready low for 3 cycles, then rsp_ready low for 2 cycles.
  - Outputs held stable throughout; req_ready low throughout.
  - ld_cycles increments by 5 for a load with a 1-cycle RDW.
- XLEN = 64:
  - ld at 0x...08 returns the full 64-bit Read_data.
  - lw at 0x...04 with Read_data 0x8000_0001_xxxx_xxxx returns 0xFFFF_FFFF_8000_0001.
- Reset mid-operation: rst_n pulsed low during RDW.
  - Expect IDLE, req_ready = 1, rsp_valid = 0.
  - A following Read_data_Valid produces no response.
